// File: rtl/path_pkg.sv
// Shared constants and FSM state encoding for the route sequencer.
package path_pkg;
    localparam int MAX_STEPS = 10;
    localparam int NODE_W    = 5;
    localparam logic [1:0] DIR_END = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAN,
        ST_WAIT,
        ST_LOAD,
        ST_ISSUE,
        ST_DONE,
        ST_ERR
    } state_t;
endpackage

// File: rtl/path_stepper.sv
// Holds a planned path and presents its directions one at a time.
// Latency: first direction valid the cycle after load; next one the cycle after acceptance.
// Backpressure: dir_code holds while dir_valid is high and dir_ready is low.
module path_stepper #(
    parameter int MAX_STEPS = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [2*MAX_STEPS-1:0] plan_path,
    input  logic                   dir_ready,
    output logic                   empty,
    output logic                   last_accepted,
    output logic                   dir_valid,
    output logic [1:0]             dir_code
);
    import path_pkg::*;

    localparam int IW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    logic [2*MAX_STEPS-1:0] path_q;
    logic [IW-1:0]          idx;
    logic                   accept;

    // The current slot always sits in the low bits; acceptance shifts the next one down.
    assign dir_code      = path_q[1:0];
    assign empty         = (plan_path[1:0] == DIR_END);
    assign accept        = dir_valid && dir_ready;
    assign last_accepted = accept &&
                           ((idx == IW'(MAX_STEPS - 1)) || (path_q[3:2] == DIR_END));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            path_q    <= '0;
            idx       <= '0;
            dir_valid <= 1'b0;
        end else if (load) begin
            path_q    <= empty ? '0 : plan_path;
            idx       <= '0;
            dir_valid <= !empty;
        end else if (last_accepted) begin
            path_q    <= '0;
            idx       <= '0;
            dir_valid <= 1'b0;
        end else if (accept) begin
            path_q    <= path_q >> 2;
            idx       <= idx + IW'(1);
        end
    end
endmodule

// File: rtl/path_sequencer.sv
// Launches the path planner on a route request, then steps the motion block through the path.
// Latency: plan_start the cycle after go; first direction two cycles after plan_done.
// Backpressure: each direction waits on dir_ready; go is ignored while busy.
module path_sequencer #(
    parameter int MAX_STEPS    = path_pkg::MAX_STEPS,
    parameter int NODE_W       = path_pkg::NODE_W,
    parameter int START_NODE   = 0,
    parameter int START_PULSE  = 200,
    parameter int PLAN_TIMEOUT = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   go,
    input  logic [NODE_W-1:0]      goal_node,
    output logic                   plan_start,
    output logic [NODE_W-1:0]      plan_s_node,
    output logic [NODE_W-1:0]      plan_e_node,
    input  logic                   plan_done,
    input  logic [2*MAX_STEPS-1:0] plan_path,
    output logic                   dir_valid,
    output logic [1:0]             dir_code,
    input  logic                   dir_ready,
    output logic [NODE_W-1:0]      cur_node,
    output logic                   busy,
    output logic                   route_done,
    output logic                   plan_err
);
    import path_pkg::*;

    localparam int CNT_MAX = (START_PULSE > PLAN_TIMEOUT) ? START_PULSE : PLAN_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          load, empty, last_accepted;
    logic          go_new;

    assign go_new = go && (goal_node != cur_node);

    path_stepper #(
        .MAX_STEPS(MAX_STEPS)
    ) u_stepper (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .plan_path    (plan_path),
        .dir_ready    (dir_ready),
        .empty        (empty),
        .last_accepted(last_accepted),
        .dir_valid    (dir_valid),
        .dir_code     (dir_code)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE:  if (go) state_nxt = go_new ? ST_PLAN : ST_DONE;
            ST_PLAN:  if (cnt == CW'(START_PULSE - 1)) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (plan_done)                           state_nxt = ST_LOAD;
                else if (cnt == CW'(PLAN_TIMEOUT - 1))   state_nxt = ST_ERR;
            end
            ST_LOAD: begin
                load      = 1'b1;
                state_nxt = empty ? ST_ERR : ST_ISSUE;
            end
            ST_ISSUE: if (last_accepted) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            ST_ERR:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            plan_start  <= 1'b0;
            plan_s_node <= '0;
            plan_e_node <= '0;
            cur_node    <= NODE_W'(START_NODE);
            busy        <= 1'b0;
            route_done  <= 1'b0;
            plan_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            plan_start <= (state_nxt == ST_PLAN);
            busy       <= (state_nxt != ST_IDLE);
            route_done <= (state_nxt == ST_DONE);
            plan_err   <= (state_nxt == ST_ERR);

            if (state_nxt != state)
                cnt <= '0;
            else if (state == ST_PLAN || state == ST_WAIT)
                cnt <= cnt + CW'(1);

            if (state == ST_IDLE && go_new) begin
                plan_s_node <= cur_node;
                plan_e_node <= goal_node;
            end

            if (state == ST_ISSUE && last_accepted)
                cur_node <= plan_e_node;
        end
    end
endmodule

// File: tb/tb_path_sequencer.sv
// Directed bench for path_sequencer: planner and motion block are modelled by the stimulus.
module tb_path_sequencer;
    localparam int T_OUT = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [4:0]  goal_node = '0;
    logic        plan_done = 1'b0;
    logic [19:0] plan_path = '0;
    logic        dir_ready = 1'b0;
    logic        plan_start, dir_valid, busy, route_done, plan_err;
    logic [4:0]  plan_s_node, plan_e_node, cur_node;
    logic [1:0]  dir_code;

    int n_chk = 0;
    int n_fail = 0;
    int unstable = 0;
    logic [1:0] acc_q[$];
    logic [1:0] exp_q[$];
    int acc_cyc[$];

    path_sequencer #(
        .MAX_STEPS(10), .NODE_W(5), .START_NODE(0),
        .START_PULSE(200), .PLAN_TIMEOUT(T_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .goal_node(goal_node),
        .plan_start(plan_start), .plan_s_node(plan_s_node), .plan_e_node(plan_e_node),
        .plan_done(plan_done), .plan_path(plan_path),
        .dir_valid(dir_valid), .dir_code(dir_code), .dir_ready(dir_ready),
        .cur_node(cur_node), .busy(busy), .route_done(route_done), .plan_err(plan_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [19:0] mk_path();
        logic [19:0] p = '0;
        for (int i = 0; i < exp_q.size(); i++) p[2*i +: 2] = exp_q[i];
        return p;
    endfunction

    task automatic go_plan(input logic [4:0] goal, input logic [4:0] exp_s);
        int n = 0;
        goal_node = goal;
        go = 1'b1;
        tick();
        go = 1'b0;
        check("busy_rise", 32'(busy), 1);
        check("s_node", 32'(plan_s_node), 32'(exp_s));
        check("e_node", 32'(plan_e_node), 32'(goal));
        while (plan_start && n < 1000) begin
            n++;
            tick();
        end
        check("start_len", n, 200);
    endtask

    task automatic give_path(input logic [19:0] p, input int dly);
        tick(dly);
        plan_path = p;
        plan_done = 1'b1;
        tick();
        plan_done = 1'b0;
        check("load_no_vld", 32'(dir_valid), 0);
    endtask

    task automatic run_issue(input int dly);
        int wait_n = 0;
        logic [1:0] held = 2'b00;
        acc_q.delete();
        acc_cyc.delete();
        unstable = 0;
        for (int c = 0; c < 3000 && !route_done && !plan_err; c++) begin
            if (dir_valid) begin
                if (wait_n > 0 && dir_code !== held) unstable++;
                held = dir_code;
                if (wait_n >= dly) begin
                    dir_ready = 1'b1;
                    acc_q.push_back(dir_code);
                    acc_cyc.push_back(c);
                    wait_n = 0;
                end else begin
                    dir_ready = 1'b0;
                    wait_n++;
                end
            end else begin
                dir_ready = (dly == 0);
            end
            tick();
        end
        dir_ready = 1'b0;
    endtask

    task automatic cmp_codes(input string tag);
        check({tag, "_n"}, acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check(tag, (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    endtask

    task automatic end_route(input logic [4:0] exp_node);
        check("rd_pulse", 32'(route_done), 1);
        check("vld_low", 32'(dir_valid), 0);
        check("busy_done", 32'(busy), 1);
        tick();
        check("rd_once", 32'(route_done), 0);
        check("busy_fall", 32'(busy), 0);
        check("cur_node", 32'(cur_node), 32'(exp_node));
    endtask

    task automatic check_reset();
        check("rst_start", 32'(plan_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_vld", 32'(dir_valid), 0);
        check("rst_code", 32'(dir_code), 0);
        check("rst_done", 32'(route_done), 0);
        check("rst_err", 32'(plan_err), 0);
        check("rst_snode", 32'(plan_s_node), 0);
        check("rst_enode", 32'(plan_e_node), 0);
        check("rst_cur", 32'(cur_node), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        tick(2);
        check_reset();
        rst_n = 1'b1;
        tick();

        // Route 0 -> 3: slots 01,11,10,00; planner answers 500 cycles after go.
        go_plan(5'd3, 5'd0);
        give_path(20'h0002D, 299);
        tick();
        check("first_vld", 32'(dir_valid), 1);
        check("first_code", 32'(dir_code), 1);
        run_issue(2);
        exp_q = '{2'b01, 2'b11, 2'b10};
        cmp_codes("t1_code");
        end_route(5'd3);

        // Route 3 -> 7: full 10-slot path with dir_ready held high.
        exp_q = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01};
        go_plan(5'd7, 5'd3);
        give_path(mk_path(), 20);
        tick();
        run_issue(0);
        cmp_codes("t2_code");
        check("t2_b2b", (acc_cyc.size() == 10) ? acc_cyc[9] - acc_cyc[0] : -1, 9);
        end_route(5'd7);

        // Route 7 -> 12 with a 7-cycle ready delay on every step.
        exp_q = '{2'b11, 2'b01, 2'b10, 2'b10};
        go_plan(5'd12, 5'd7);
        give_path(mk_path(), 4);
        tick();
        run_issue(7);
        check("t3_stable", unstable, 0);
        cmp_codes("t3_code");
        end_route(5'd12);

        // Planner never finishes: timeout counted from the first WAIT cycle.
        go_plan(5'd20, 5'd12);
        j = 0;
        while (!plan_err && j < 3 * T_OUT) begin
            tick();
            j++;
        end
        check("tmo_cycles", j, T_OUT);
        check("tmo_cur", 32'(cur_node), 12);
        tick();
        check("tmo_err_once", 32'(plan_err), 0);
        check("tmo_busy", 32'(busy), 0);

        // Empty path: slot 0 is the end marker.
        go_plan(5'd5, 5'd12);
        give_path(20'hFFFFC, 10);
        tick();
        check("empty_err", 32'(plan_err), 1);
        check("empty_vld", 32'(dir_valid), 0);
        check("empty_rd", 32'(route_done), 0);
        tick();
        check("empty_err_once", 32'(plan_err), 0);
        check("empty_busy", 32'(busy), 0);
        check("empty_cur", 32'(cur_node), 12);

        // Goal equals current node: completes without starting the planner.
        goal_node = 5'd12;
        go = 1'b1;
        tick();
        go = 1'b0;
        check("same_rd", 32'(route_done), 1);
        check("same_nostart", 32'(plan_start), 0);
        check("same_busy", 32'(busy), 1);
        tick();
        check("same_rd_once", 32'(route_done), 0);
        check("same_idle", 32'(busy), 0);
        check("same_nostart2", 32'(plan_start), 0);
        check("same_cur", 32'(cur_node), 12);

        // Route 12 -> 9, stray go during ISSUE, then reset mid-route.
        exp_q = '{2'b01, 2'b10, 2'b11};
        go_plan(5'd9, 5'd12);
        give_path(mk_path(), 5);
        tick();
        check("t7_vld", 32'(dir_valid), 1);
        goal_node = 5'd30;
        go = 1'b1;
        tick();
        go = 1'b0;
        check("t7_go_vld", 32'(dir_valid), 1);
        check("t7_go_code", 32'(dir_code), 1);
        check("t7_go_nostart", 32'(plan_start), 0);
        check("t7_go_enode", 32'(plan_e_node), 9);
        tick(3);
        check("t7_hold", 32'(dir_code), 1);
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
        check("t7_next_vld", 32'(dir_valid), 1);
        check("t7_next_code", 32'(dir_code), 2);
        rst_n = 1'b0;
        #1;
        check_reset();
        tick();
        rst_n = 1'b1;
        tick();

        // After reset the old path is gone; a fresh route 0 -> 2 works normally.
        exp_q = '{2'b10};
        go_plan(5'd2, 5'd0);
        give_path(mk_path(), 3);
        tick();
        run_issue(1);
        cmp_codes("t8_code");
        end_route(5'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
